// File: rtl/pkt_tx_arb_pkg.sv
// Shared types and widths for the packet TX arbiter.
package pkt_tx_arb_pkg;

  localparam int PKT_WORD_W = 64;
  localparam int PKT_MOD_W  = 3;
  localparam int STAT_CNT_W = 32;

  // One-hot arbiter states
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SELECT = 3'b010,
    XFER   = 3'b100
  } arbState_e;

endpackage

// File: rtl/pkt_tx_rr_sel.sv
// Combinational winner selector: request vector plus search pointer in,
// one-hot winner and its index out. STRICT_PRIO=1 ignores the pointer and
// always favours the lowest-index requester.
module pkt_tx_rr_sel
  import pkt_tx_arb_pkg::*;
#(
  parameter int PORTS_NUM   = 4,
  parameter int STRICT_PRIO = 0,
  parameter int PTR_W       = 2
) (
  input  logic [PORTS_NUM-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [PORTS_NUM-1:0] gnt_o,
  output logic [PTR_W-1:0]     gntIdx_o
);

  // Scan the ports starting at the pointer (or at port 0) and take the first requester
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt_o    = '0;
    gntIdx_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < PORTS_NUM; i++) begin
      if (STRICT_PRIO != 0) begin
        idx = PTR_W'(i);
      end else begin
        idx = PTR_W'((int'(ptr_i) + i) % PORTS_NUM);
      end
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gntIdx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Packet TX arbiter: merges PORTS_NUM packet sources onto one 64-bit stream
// toward the 1G TX converter, one whole packet at a time.
// Optional build macro PKT_TX_ARB_STAT_EN adds per-port forwarded-packet
// counters; without it pkt_cnt_o is tied to zero.
module pkt_tx_arbiter
  import pkt_tx_arb_pkg::*;
#(
  parameter int PORTS_NUM   = 4,
  parameter int STRICT_PRIO = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [PKT_WORD_W*PORTS_NUM-1:0]  src_data_i,
  input  logic [PKT_MOD_W*PORTS_NUM-1:0]   src_mod_i,
  input  logic [PORTS_NUM-1:0]             src_sop_i,
  input  logic [PORTS_NUM-1:0]             src_eop_i,
  input  logic [PORTS_NUM-1:0]             src_val_i,
  output logic [PORTS_NUM-1:0]             src_ready_o,
  output logic [PKT_WORD_W-1:0]            pkt_tx_data_o,
  output logic [PKT_MOD_W-1:0]             pkt_tx_mod_o,
  output logic                             pkt_tx_sop_o,
  output logic                             pkt_tx_eop_o,
  output logic                             pkt_tx_val_o,
  input  logic                             tx_fifo_full_i,
  output logic [PORTS_NUM-1:0]             grant_o,
  output logic [STAT_CNT_W*PORTS_NUM-1:0]  pkt_cnt_o
);

  localparam int PTR_W = (PORTS_NUM > 1) ? $clog2(PORTS_NUM) : 1;

  arbState_e              state_q, state_d;
  logic [PORTS_NUM-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]       grantIdx_q, grantIdx_d;
  logic [PTR_W-1:0]       rrPtr_q, rrPtr_d;
  logic                   firstWord_q, firstWord_d;

  logic [PORTS_NUM-1:0]   sopReq;
  logic [PORTS_NUM-1:0]   selGnt;
  logic [PTR_W-1:0]       selIdx;
  logic                   accept;

  logic [PKT_WORD_W-1:0]  gntData;
  logic [PKT_MOD_W-1:0]   gntMod;
  logic                   gntSop;
  logic                   gntEop;
  logic                   gntVal;

  logic [PKT_WORD_W-1:0]  txData_q;
  logic [PKT_MOD_W-1:0]   txMod_q;
  logic                   txSop_q;
  logic                   txEop_q;
  logic                   txVal_q;

  assign sopReq = src_val_i & src_sop_i;

  pkt_tx_rr_sel #(
    .PORTS_NUM   (PORTS_NUM),
    .STRICT_PRIO (STRICT_PRIO),
    .PTR_W       (PTR_W)
  ) uSel (
    .req_i    (sopReq),
    .ptr_i    (rrPtr_q),
    .gnt_o    (selGnt),
    .gntIdx_o (selIdx)
  );

  // Route the currently granted port's word fields onto a single set of wires
  always_comb begin
    gntData = '0;
    gntMod  = '0;
    gntSop  = 1'b0;
    gntEop  = 1'b0;
    gntVal  = 1'b0;
    for (int k = 0; k < PORTS_NUM; k++) begin
      if (grantIdx_q == PTR_W'(k)) begin
        gntData = src_data_i[k*PKT_WORD_W +: PKT_WORD_W];
        gntMod  = src_mod_i[k*PKT_MOD_W +: PKT_MOD_W];
        gntSop  = src_sop_i[k];
        gntEop  = src_eop_i[k];
        gntVal  = src_val_i[k];
      end
    end
  end

  // Next-state, grant bookkeeping and source ready generation
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grantIdx_d  = grantIdx_q;
    rrPtr_d     = rrPtr_q;
    firstWord_d = firstWord_q;
    src_ready_o = '0;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        src_ready_o = src_val_i & ~src_sop_i;
        if (|sopReq) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (|sopReq) begin
          grant_d     = selGnt;
          grantIdx_d  = selIdx;
          rrPtr_d     = (selIdx == PTR_W'(PORTS_NUM - 1)) ? '0 : selIdx + PTR_W'(1);
          firstWord_d = 1'b1;
          state_d     = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        src_ready_o = grant_q & {PORTS_NUM{~tx_fifo_full_i}};
        accept      = gntVal & ~tx_fifo_full_i;
        if (accept) begin
          firstWord_d = 1'b0;
          if (gntEop) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst_i) begin
      src_ready_o = '0;
    end
  end

  // FSM state, owner and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grantIdx_q  <= '0;
      rrPtr_q     <= '0;
      firstWord_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grantIdx_q  <= grantIdx_d;
      rrPtr_q     <= rrPtr_d;
      firstWord_q <= firstWord_d;
    end
  end

  // Register each accepted word toward the converter; a mid-packet sop goes out as plain data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txData_q <= '0;
      txMod_q  <= '0;
      txSop_q  <= 1'b0;
      txEop_q  <= 1'b0;
      txVal_q  <= 1'b0;
    end else begin
      txVal_q <= accept;
      txSop_q <= accept & gntSop & firstWord_q;
      txEop_q <= accept & gntEop;
      if (accept) begin
        txData_q <= gntData;
        txMod_q  <= gntMod;
      end
    end
  end

  assign pkt_tx_data_o = txData_q;
  assign pkt_tx_mod_o  = txMod_q;
  assign pkt_tx_sop_o  = txSop_q;
  assign pkt_tx_eop_o  = txEop_q;
  assign pkt_tx_val_o  = txVal_q;
  assign grant_o       = grant_q;

`ifdef PKT_TX_ARB_STAT_EN
  logic [STAT_CNT_W-1:0] pktCnt_q [PORTS_NUM];

  // Per-port packet counters, bumped on each accepted end of packet and free to wrap
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < PORTS_NUM; k++) begin
      if (rst_i) begin
        pktCnt_q[k] <= '0;
      end else if (accept && gntEop && (grantIdx_q == PTR_W'(k))) begin
        pktCnt_q[k] <= pktCnt_q[k] + STAT_CNT_W'(1);
      end
    end
  end

  // Flatten the counter array onto the output bus
  always_comb begin
    pkt_cnt_o = '0;
    for (int k = 0; k < PORTS_NUM; k++) begin
      pkt_cnt_o[k*STAT_CNT_W +: STAT_CNT_W] = pktCnt_q[k];
    end
  end
`else
  assign pkt_cnt_o = '0;
`endif

endmodule
